// File: rtl/nios2_ocimem_pkg.sv
// rtl/nios2_ocimem_pkg.sv - shared state encoding and jdo field positions for the debug-memory controller
package nios2_ocimem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_CPU
  } ocimem_state_e;

  localparam int JDO_RDFLAG_BIT = 17;
  localparam int JDO_ADDR_LSB   = 2;
  localparam int JDO_DATA_LSB   = 3;
  localparam int JDO_DATA_MSB   = 34;

endpackage

// File: rtl/nios2_ocimem_ram.sv
// rtl/nios2_ocimem_ram.sv - single-port DEPTHx32 debug RAM, registered address, one-cycle read latency
module nios2_ocimem_ram #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  // Write when enabled; read data is the word at the address sampled on this edge
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/nios2_jtag_ocimem_ctrl.sv
// rtl/nios2_jtag_ocimem_ctrl.sv - JTAG debug-memory command executor with a stalled CPU read port
module nios2_jtag_ocimem_ctrl
  import nios2_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  ocimem_state_e     state_q, state_d;
  logic              acc_a, acc_na, acc_b, cpu_acc, busy, any_pulse;
  logic              ram_we, addr_oor, cpu_pending, cpu_oor_q;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_rdata;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[1:0]};

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  // The last implemented word wraps to 0; anything beyond it also lands on 0
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= DEPTH_W - 1'b1) ? '0 : a + 1'b1;
  endfunction

  assign any_pulse = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign addr_oor  = !in_range(MonAReg);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command decode with JTAG-over-CPU priority, next state and RAM port control
  always_comb begin
    state_d  = state_q;
    acc_a    = 1'b0;
    acc_na   = 1'b0;
    acc_b    = 1'b0;
    cpu_acc  = 1'b0;
    ram_we   = 1'b0;
    ram_addr = MonAReg;
    busy     = (state_q != ST_IDLE) && any_pulse;
    case (state_q)
      ST_IDLE: begin
        if (take_action_ocimem_b) begin
          acc_b   = 1'b1;
          state_d = ST_WR;
        end else if (take_action_ocimem_a) begin
          acc_a = 1'b1;
          if (jdo[JDO_RDFLAG_BIT]) state_d = ST_RD;
        end else if (take_no_action_ocimem_a) begin
          acc_na  = 1'b1;
          state_d = ST_RD;
        end else if (cpu_read) begin
          cpu_acc  = 1'b1;
          ram_addr = cpu_address;
          state_d  = ST_CPU;
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  state_d = ST_IDLE;
      ST_WR: begin
        ram_we  = !addr_oor;
        state_d = ST_IDLE;
      end
      ST_CPU:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Monitor registers: address/data tracking, completion and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MonDReg       <= '0;
      MonAReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      if (busy) monitor_error <= 1'b1;
      if (acc_a) begin
        MonAReg       <= jdo[JDO_ADDR_LSB +: ADDR_W];
        monitor_error <= 1'b0;
        monitor_ready <= !jdo[JDO_RDFLAG_BIT];
      end
      if (acc_na) begin
        MonAReg       <= next_addr(MonAReg);
        monitor_ready <= 1'b0;
      end
      if (acc_b) begin
        MonDReg       <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
        monitor_ready <= 1'b0;
      end
      if (state_q == ST_RD && addr_oor) monitor_error <= 1'b1;
      if (state_q == ST_CAP) begin
        if (!addr_oor) MonDReg <= ram_rdata;
        monitor_ready <= 1'b1;
      end
      if (state_q == ST_WR) begin
        if (addr_oor) monitor_error <= 1'b1;
        MonAReg       <= next_addr(MonAReg);
        monitor_ready <= 1'b1;
      end
    end
  end

  // CPU read in flight; out-of-range reads are remembered so they return zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_pending <= 1'b0;
      cpu_oor_q   <= 1'b0;
    end else if (cpu_acc) begin
      cpu_pending <= 1'b1;
      cpu_oor_q   <= !in_range(cpu_address);
    end else begin
      cpu_pending <= 1'b0;
    end
  end

  assign cpu_waitrequest = cpu_read && !cpu_pending;
  assign cpu_readdata    = (cpu_pending && !cpu_oor_q) ? ram_rdata : '0;

  nios2_ocimem_ram #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(MonDReg),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_nios2_jtag_ocimem_ctrl.sv
// tb/tb_nios2_jtag_ocimem_ctrl.sv - directed scoreboard bench for the JTAG debug-memory controller
module tb_nios2_jtag_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_a, take_na, take_b;
  logic [7:0]  cpu_address;
  logic        cpu_read;

  logic [31:0] a_cpu_rd, a_mond, b_cpu_rd, b_mond;
  logic        a_wait, a_rdy, a_err, b_wait, b_rdy, b_err;
  logic [7:0]  a_mona, b_mona;

  int tests = 0;
  int fails = 0;

  logic [31:0] sb_val[$];
  string       sb_tag[$];

  always #5 clk = ~clk;

  nios2_jtag_ocimem_ctrl #(.ADDR_W(8), .DEPTH(256)) u_dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_no_action_ocimem_a(take_na), .take_action_ocimem_b(take_b),
    .cpu_address(cpu_address), .cpu_read(cpu_read),
    .cpu_readdata(a_cpu_rd), .cpu_waitrequest(a_wait),
    .MonDReg(a_mond), .MonAReg(a_mona), .monitor_ready(a_rdy), .monitor_error(a_err)
  );

  nios2_jtag_ocimem_ctrl #(.ADDR_W(8), .DEPTH(200)) u_dut200 (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_no_action_ocimem_a(take_na), .take_action_ocimem_b(take_b),
    .cpu_address(cpu_address), .cpu_read(cpu_read),
    .cpu_readdata(b_cpu_rd), .cpu_waitrequest(b_wait),
    .MonDReg(b_mond), .MonAReg(b_mona), .monitor_ready(b_rdy), .monitor_error(b_err)
  );

  task automatic expect_val(input string tag, input logic [31:0] v);
    sb_tag.push_back(tag);
    sb_val.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    tests++;
    if (sb_val.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb_val.pop_front();
      t = sb_tag.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic [7:0] addr, input logic rd);
    jdo = '0;
    jdo[9:2] = addr;
    jdo[17] = rd;
    take_a = 1'b1;
    tick();
    take_a = 1'b0;
  endtask

  task automatic pulse_na();
    take_na = 1'b1;
    tick();
    take_na = 1'b0;
  endtask

  task automatic pulse_b(input logic [31:0] data);
    jdo = '0;
    jdo[34:3] = data;
    take_b = 1'b1;
    tick();
    take_b = 1'b0;
  endtask

  initial begin
    int          stall;
    logic        done;
    logic [31:0] got;

    reset = 1'b1; jdo = '0; take_a = 0; take_na = 0; take_b = 0;
    cpu_address = '0; cpu_read = 0;
    tick(); tick();

    expect_val("rst_mondreg", 32'h0);     check(a_mond);
    expect_val("rst_monareg", 32'h0);     check(32'(a_mona));
    expect_val("rst_ready", 32'h0);       check(32'(a_rdy));
    expect_val("rst_error", 32'h0);       check(32'(a_err));
    expect_val("rst_cpu_readdata", 32'h0); check(a_cpu_rd);
    reset = 1'b0;
    tick();

    // preload RAM[5]
    pulse_a(8'd5, 1'b0);
    expect_val("load_noread_monareg", 32'd5); check(32'(a_mona));
    expect_val("load_noread_ready", 32'd1);   check(32'(a_rdy));
    pulse_b(32'hDEADBEEF);
    tick();
    expect_val("write_postinc", 32'd6); check(32'(a_mona));

    // JTAG read of addr 5
    pulse_a(8'd5, 1'b1);
    expect_val("read_ready_cleared", 32'd0); check(32'(a_rdy));
    tick(); tick();
    expect_val("read_mondreg", 32'hDEADBEEF); check(a_mond);
    expect_val("read_ready", 32'd1);          check(32'(a_rdy));
    expect_val("read_monareg", 32'd5);        check(32'(a_mona));
    expect_val("d200_read_mondreg", 32'hDEADBEEF); check(b_mond);

    // out-of-range read on the DEPTH=200 instance
    pulse_a(8'd210, 1'b1);
    tick(); tick();
    expect_val("oor_read_error", 32'd1);          check(32'(b_err));
    expect_val("oor_read_mondreg", 32'hDEADBEEF); check(b_mond);
    expect_val("oor_read_ready", 32'd1);          check(32'(b_rdy));
    pulse_a(8'd3, 1'b0);
    expect_val("oor_error_cleared", 32'd0); check(32'(b_err));

    // write at the last word, address wraps
    pulse_a(8'd255, 1'b0);
    pulse_b(32'h12345678);
    expect_val("wr_monareg_in_wr", 32'd255); check(32'(a_mona));
    expect_val("wr_ready_in_wr", 32'd0);     check(32'(a_rdy));
    tick();
    expect_val("wr_wrap_monareg", 32'd0); check(32'(a_mona));
    expect_val("wr_ready", 32'd1);        check(32'(a_rdy));
    expect_val("d200_oor_write_error", 32'd1); check(32'(b_err));

    // read back 255 via increment-and-read
    pulse_a(8'd5, 1'b1);
    tick(); tick();
    pulse_a(8'd254, 1'b0);
    pulse_na();
    tick(); tick();
    expect_val("incread_monareg", 32'd255);      check(32'(a_mona));
    expect_val("incread_mondreg", 32'h12345678); check(a_mond);
    pulse_na();
    tick(); tick();
    expect_val("incread_wrap", 32'd0); check(32'(a_mona));

    // pulse while busy in RD
    pulse_a(8'd5, 1'b1);
    pulse_b(32'h0BAD0BAD);
    tick();
    expect_val("busy_error", 32'd1);          check(32'(a_err));
    expect_val("busy_mondreg", 32'hDEADBEEF); check(a_mond);
    expect_val("busy_ready", 32'd1);          check(32'(a_rdy));
    expect_val("busy_monareg", 32'd5);        check(32'(a_mona));

    // CPU read colliding with a JTAG write
    pulse_a(8'd7, 1'b0);
    pulse_b(32'hCAFEF00D);
    tick();
    jdo = '0; jdo[34:3] = 32'h0BADF00D; take_b = 1'b1;
    cpu_address = 8'd7; cpu_read = 1'b1;
    expect_val("cpu_done", 32'd1);
    expect_val("cpu_stall_cycles", 32'd3);
    expect_val("cpu_readdata", 32'hCAFEF00D);
    stall = 0; done = 1'b0; got = '0;
    for (int i = 0; i < 10 && !done; i++) begin
      #1;
      if (!a_wait) begin
        done = 1'b1;
        got = a_cpu_rd;
      end else begin
        stall++;
        @(posedge clk); #1;
        take_b = 1'b0;
      end
    end
    cpu_read = 1'b0;
    check(32'(done));
    check(32'(stall));
    check(got);
    tick();

    // out-of-range CPU read on the DEPTH=200 instance
    pulse_a(8'd3, 1'b0);
    cpu_address = 8'd250; cpu_read = 1'b1;
    #1;
    expect_val("cpu_oor_wait_accept", 32'd1); check(32'(b_wait));
    tick();
    expect_val("cpu_oor_wait_done", 32'd0); check(32'(b_wait));
    expect_val("cpu_oor_readdata", 32'd0);  check(b_cpu_rd);
    cpu_read = 1'b0;
    tick();
    expect_val("cpu_oor_no_error", 32'd0); check(32'(b_err));

    // reset during WR drops the write
    pulse_a(8'd9, 1'b0);
    pulse_b(32'h11111111);
    tick();
    pulse_a(8'd9, 1'b0);
    pulse_b(32'h22222222);
    #2;
    reset = 1'b1;
    #1;
    expect_val("midrst_mondreg", 32'h0); check(a_mond);
    expect_val("midrst_monareg", 32'h0); check(32'(a_mona));
    expect_val("midrst_ready", 32'h0);   check(32'(a_rdy));
    expect_val("midrst_error", 32'h0);   check(32'(a_err));
    tick();
    reset = 1'b0;
    tick();
    pulse_a(8'd9, 1'b1);
    tick(); tick();
    expect_val("midrst_no_write", 32'h11111111); check(a_mond);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
